// File: rtl/tcp_misc_pkg.sv
// Shared TCP TX datapath types.
//   tcp_pkt_hdr        : assembled TCP header as produced by the header builder
//   payload_buf_struct : payload buffer address and byte length
//   tx_pkt_desc_struct : one TX descriptor; also the storage word of the TX queue
package tcp_misc_pkg;

  localparam int FLOWID_W       = 8;
  localparam int IP_ADDR_W      = 32;
  localparam int PAYLOAD_ADDR_W = 32;
  localparam int PAYLOAD_LEN_W  = 32;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [3:0]  data_offset;
    logic [7:0]  flags;
    logic [15:0] window;
  } tcp_pkt_hdr;

  typedef struct packed {
    logic [PAYLOAD_ADDR_W-1:0] payload_addr;
    logic [PAYLOAD_LEN_W-1:0]  payload_len;
  } payload_buf_struct;

  typedef struct packed {
    tcp_pkt_hdr              hdr;
    logic [FLOWID_W-1:0]     flowid;
    logic [IP_ADDR_W-1:0]    src_ip;
    logic [IP_ADDR_W-1:0]    dst_ip;
    payload_buf_struct       payload;
  } tx_pkt_desc_struct;

endpackage

// File: rtl/tcp_tx_pkt_queue_stats.sv
// Dequeue statistics for the TCP TX packet queue.
//   clk, rst_n     : clock, async active-low reset
//   pop            : a descriptor leaves the queue this cycle
//   pop_len        : payload length of that descriptor (already zero-extended)
//   stat_clear     : synchronous clear, wins over a coincident pop
//   stat_pkt_cnt   : packets dequeued (wraps mod 2^32)
//   stat_byte_cnt  : payload bytes dequeued (wraps mod 2^32)
module tcp_tx_pkt_queue_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pop,
  input  logic [31:0] pop_len,
  input  logic        stat_clear,
  output logic [31:0] stat_pkt_cnt,
  output logic [31:0] stat_byte_cnt
);

  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    byte_cnt_d = byte_cnt_q;
    if (stat_clear) begin
      pkt_cnt_d  = '0;
      byte_cnt_d = '0;
    end else if (pop) begin
      pkt_cnt_d  = pkt_cnt_q + 32'd1;
      byte_cnt_d = byte_cnt_q + pop_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_byte_cnt = byte_cnt_q;

endmodule

// File: rtl/tcp_tx_pkt_queue.sv
// First-word-fall-through queue of TCP TX descriptors between the TX
// scheduler and the packet assembler, with dequeue statistics.
//   clk, rst_n          : clock, async active-low reset
//   pkt_in_*            : descriptor push side (val/rdy handshake)
//   pkt_out_*           : head descriptor pop side (val/rdy handshake)
//   queue_count         : current occupancy
//   queue_afull         : registered almost-full (count >= AFULL_THRESH)
//   stat_clear          : clear the statistics counters
//   stat_pkt_cnt/_byte_cnt : dequeued packets / payload bytes
module tcp_tx_pkt_queue
  import tcp_misc_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pkt_in_val,
  output logic                         pkt_in_rdy,
  input  tcp_pkt_hdr                   pkt_in_hdr,
  input  logic [FLOWID_W-1:0]          pkt_in_flowid,
  input  logic [IP_ADDR_W-1:0]         pkt_in_src_ip,
  input  logic [IP_ADDR_W-1:0]         pkt_in_dst_ip,
  input  payload_buf_struct            pkt_in_payload,
  output logic                         pkt_out_val,
  input  logic                         pkt_out_rdy,
  output tcp_pkt_hdr                   pkt_out_hdr,
  output logic [FLOWID_W-1:0]          pkt_out_flowid,
  output logic [IP_ADDR_W-1:0]         pkt_out_src_ip,
  output logic [IP_ADDR_W-1:0]         pkt_out_dst_ip,
  output payload_buf_struct            pkt_out_payload,
  output logic [$clog2(DEPTH):0]       queue_count,
  output logic                         queue_afull,
  input  logic                         stat_clear,
  output logic [31:0]                  stat_pkt_cnt,
  output logic [31:0]                  stat_byte_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tcp_tx_pkt_queue: DEPTH must be a power of 2 and >= 2");
  end

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              afull_q, afull_d;
  logic              push, pop;
  tx_pkt_desc_struct in_desc, head_desc;

  // Storage is intentionally not reset; stale words are masked by pkt_out_val.
  tx_pkt_desc_struct mem_q [DEPTH];

  // Ready depends only on occupancy, so a full queue never accepts a push
  // even when the head is popped in the same cycle.
  assign pkt_in_rdy  = (count_q != CW'(DEPTH));
  assign pkt_out_val = (count_q != '0);
  assign push        = pkt_in_val & pkt_in_rdy;
  assign pop         = pkt_out_val & pkt_out_rdy;

  assign in_desc = '{hdr: pkt_in_hdr, flowid: pkt_in_flowid, src_ip: pkt_in_src_ip,
                     dst_ip: pkt_in_dst_ip, payload: pkt_in_payload};

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Computed from the next count so afull lines up with queue_count.
    afull_d = (int'(count_d) >= AFULL_THRESH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_desc;
  end

  assign head_desc       = mem_q[rd_ptr_q];
  assign pkt_out_hdr     = head_desc.hdr;
  assign pkt_out_flowid  = head_desc.flowid;
  assign pkt_out_src_ip  = head_desc.src_ip;
  assign pkt_out_dst_ip  = head_desc.dst_ip;
  assign pkt_out_payload = head_desc.payload;
  assign queue_count     = count_q;
  assign queue_afull     = afull_q;

  tcp_tx_pkt_queue_stats u_stats (
    .clk           (clk),
    .rst_n         (rst_n),
    .pop           (pop),
    .pop_len       (32'(head_desc.payload.payload_len)),
    .stat_clear    (stat_clear),
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_byte_cnt (stat_byte_cnt)
  );

endmodule

// File: tb/tb_tcp_tx_pkt_queue.sv
// Self-checking bench for tcp_tx_pkt_queue: a fill/drain vector table,
// directed multi-cycle sequences, and a randomized run against a queue model.
module tb_tcp_tx_pkt_queue;
  import tcp_misc_pkg::*;

  localparam int DEPTH = 8;
  localparam int THR   = DEPTH - 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_val = 1'b0, out_rdy = 1'b0, clr = 1'b0;
  tx_pkt_desc_struct drv = '0;
  tx_pkt_desc_struct got;

  logic                 in_rdy, out_val, afull;
  tcp_pkt_hdr           o_hdr;
  logic [FLOWID_W-1:0]  o_flowid;
  logic [IP_ADDR_W-1:0] o_src, o_dst;
  payload_buf_struct    o_pay;
  logic [CW-1:0]        cnt;
  logic [31:0]          s_pkt, s_byte;

  always #5 clk = ~clk;

  tcp_tx_pkt_queue #(.DEPTH(DEPTH), .AFULL_THRESH(THR)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_in_val(in_val), .pkt_in_rdy(in_rdy),
    .pkt_in_hdr(drv.hdr), .pkt_in_flowid(drv.flowid),
    .pkt_in_src_ip(drv.src_ip), .pkt_in_dst_ip(drv.dst_ip),
    .pkt_in_payload(drv.payload),
    .pkt_out_val(out_val), .pkt_out_rdy(out_rdy),
    .pkt_out_hdr(o_hdr), .pkt_out_flowid(o_flowid),
    .pkt_out_src_ip(o_src), .pkt_out_dst_ip(o_dst),
    .pkt_out_payload(o_pay),
    .queue_count(cnt), .queue_afull(afull),
    .stat_clear(clr), .stat_pkt_cnt(s_pkt), .stat_byte_cnt(s_byte)
  );

  assign got = {o_hdr, o_flowid, o_src, o_dst, o_pay};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_desc(input string name, input tx_pkt_desc_struct exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic tx_pkt_desc_struct mk(input logic [7:0] fid, input logic [31:0] len);
    tx_pkt_desc_struct d;
    d.hdr     = {$urandom, $urandom, $urandom, $urandom};
    d.flowid  = fid;
    d.src_ip  = $urandom;
    d.dst_ip  = $urandom;
    d.payload.payload_addr = $urandom;
    d.payload.payload_len  = len;
    return d;
  endfunction

  // Drive one cycle's inputs (just after a negedge) and advance to the next negedge.
  task automatic cyc(input logic v, input tx_pkt_desc_struct d, input logic r, input logic c);
    in_val = v; drv = d; out_rdy = r; clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_val = 1'b0; out_rdy = 1'b0; clr = 1'b0; drv = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic          val;
    logic [7:0]    fid;
    logic          rdy;
    logic [CW-1:0] e_cnt;
    logic          e_oval;
    logic          e_irdy;
    logic          e_afull;
    logic [7:0]    e_head;
  } vec_t;

  vec_t vt[18];

  tx_pkt_desc_struct mq[$];
  logic [31:0] m_pkt, m_byte;

  initial begin
    // Fill 9 (the 9th must bounce), then drain 9 (the last pops an empty queue).
    for (int i = 0; i < 9; i++) begin
      int c;
      c = (i < 8) ? i + 1 : 8;
      vt[i].val = 1'b1; vt[i].fid = 8'(i); vt[i].rdy = 1'b0;
      vt[i].e_cnt = CW'(c); vt[i].e_oval = 1'b1; vt[i].e_irdy = (c != DEPTH);
      vt[i].e_afull = (c >= THR); vt[i].e_head = 8'd0;
    end
    for (int i = 0; i < 9; i++) begin
      int c;
      c = (i < 8) ? 7 - i : 0;
      vt[9+i].val = 1'b0; vt[9+i].fid = 8'hEE; vt[9+i].rdy = 1'b1;
      vt[9+i].e_cnt = CW'(c); vt[9+i].e_oval = (c != 0); vt[9+i].e_irdy = 1'b1;
      vt[9+i].e_afull = (c >= THR); vt[9+i].e_head = 8'(i + 1);
    end

    // Reset state, sampled both during and right after reset.
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_oval", 64'(out_val), 64'd0);
    chk("rst_irdy", 64'(in_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_afull", 64'(afull), 64'd0);
    chk("rst_spkt", 64'(s_pkt), 64'd0);
    chk("rst_sbyte", 64'(s_byte), 64'd0);

    // Vector table: fill to full, then drain.
    foreach (vt[k]) begin
      cyc(vt[k].val, mk(vt[k].fid, 32'd64), vt[k].rdy, 1'b0);
      chk($sformatf("vt%0d_cnt", k), 64'(cnt), 64'(vt[k].e_cnt));
      chk($sformatf("vt%0d_oval", k), 64'(out_val), 64'(vt[k].e_oval));
      chk($sformatf("vt%0d_irdy", k), 64'(in_rdy), 64'(vt[k].e_irdy));
      chk($sformatf("vt%0d_afull", k), 64'(afull), 64'(vt[k].e_afull));
      if (vt[k].e_oval) chk($sformatf("vt%0d_head", k), 64'(o_flowid), 64'(vt[k].e_head));
    end
    idle_inputs();

    // Single descriptor flow: flowid 3, 100 bytes.
    begin
      tx_pkt_desc_struct d;
      do_reset();
      @(negedge clk);
      d = mk(8'd3, 32'd100);
      cyc(1'b1, d, 1'b1, 1'b0);
      chk("one_val", 64'(out_val), 64'd1);
      chk("one_cnt1", 64'(cnt), 64'd1);
      chk_desc("one_head", d);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("one_cnt0", 64'(cnt), 64'd0);
      chk("one_spkt", 64'(s_pkt), 64'd1);
      chk("one_sbyte", 64'(s_byte), 64'd100);
    end

    // Steady push+pop at count 4 for 20 cycles; pointers wrap.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) cyc(1'b1, mk(8'(i), 32'd1), 1'b0, 1'b0);
    chk("pp_fill_cnt", 64'(cnt), 64'd4);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("pp%0d_head", i), 64'(o_flowid), 64'(i));
      cyc(1'b1, mk(8'(i + 4), 32'd1), 1'b1, 1'b0);
      chk($sformatf("pp%0d_cnt", i), 64'(cnt), 64'd4);
    end
    chk("pp_end_head", 64'(o_flowid), 64'd20);
    chk("pp_spkt", 64'(s_pkt), 64'd20);

    // Byte counter wrap, zero-length ACK, clear beating a pop.
    do_reset();
    @(negedge clk);
    cyc(1'b1, mk(8'd1, 32'hFFFF_FFF0), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_pre", 64'(s_byte), 64'hFFFF_FFF0);
    cyc(1'b1, mk(8'd2, 32'h20), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_byte", 64'(s_byte), 64'h10);
    chk("wrap_pkt", 64'(s_pkt), 64'd2);
    cyc(1'b1, mk(8'd3, 32'd0), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("ack_byte", 64'(s_byte), 64'h10);
    chk("ack_pkt", 64'(s_pkt), 64'd3);
    cyc(1'b1, mk(8'd4, 32'd5), 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    chk("clr_pkt", 64'(s_pkt), 64'd0);
    chk("clr_byte", 64'(s_byte), 64'd0);
    chk("clr_popped", 64'(cnt), 64'd0);
    idle_inputs();

    // Asynchronous reset with 5 entries queued.
    begin
      tx_pkt_desc_struct d;
      do_reset();
      @(negedge clk);
      for (int i = 0; i < 5; i++) cyc(1'b1, mk(8'(i + 16), 32'd10), 1'b0, 1'b0);
      chk("mr_cnt5", 64'(cnt), 64'd5);
      idle_inputs();
      #2 rst_n = 1'b0;
      #1;
      chk("mr_oval", 64'(out_val), 64'd0);
      chk("mr_cnt", 64'(cnt), 64'd0);
      chk("mr_irdy", 64'(in_rdy), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      d = mk(8'hAA, 32'd7);
      cyc(1'b1, d, 1'b0, 1'b0);
      chk("mr_new_cnt", 64'(cnt), 64'd1);
      chk_desc("mr_new_head", d);
    end

    // Randomized traffic against the queue model.
    do_reset();
    @(negedge clk);
    mq.delete();
    m_pkt = '0;
    m_byte = '0;
    for (int t = 0; t < 10000; t++) begin
      logic v, r, c, do_push, do_pop;
      tx_pkt_desc_struct d;
      chk("rnd_cnt", 64'(cnt), 64'(mq.size()));
      chk("rnd_oval", 64'(out_val), 64'(mq.size() != 0));
      chk("rnd_irdy", 64'(in_rdy), 64'(mq.size() != DEPTH));
      chk("rnd_afull", 64'(afull), 64'(mq.size() >= THR));
      chk("rnd_spkt", 64'(s_pkt), 64'(m_pkt));
      chk("rnd_sbyte", 64'(s_byte), 64'(m_byte));
      if (mq.size() != 0) chk_desc("rnd_head", mq[0]);
      v = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 199) == 0);
      d = mk(8'($urandom), ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 1500)));
      do_push = v && (mq.size() != DEPTH);
      do_pop  = r && (mq.size() != 0);
      if (c) begin
        m_pkt = '0;
        m_byte = '0;
      end else if (do_pop) begin
        m_pkt  = m_pkt + 1;
        m_byte = m_byte + mq[0].payload.payload_len;
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(d);
      cyc(v, d, r, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tcp_tx_pkt_queue.md
TCP_TX_PKT_QUEUE -- requirements
Module: tcp_tx_pkt_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the entry count; must be a power of 2 and at least 2.
REQ-002 SHALL have parameter AFULL_THRESH, default DEPTH-2, meaning the count at or above which queue_afull asserts.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port pkt_in_val, input, 1 bit: a TX datap descriptor is valid.
REQ-006 SHALL have port pkt_in_rdy, output, 1 bit: the queue can accept a descriptor.
REQ-007 SHALL have port pkt_in_hdr, input, tcp_pkt_hdr: the assembled TCP header.
REQ-008 SHALL have port pkt_in_flowid, input, FLOWID_W: the flow id.
REQ-009 SHALL have ports pkt_in_src_ip and pkt_in_dst_ip, inputs, IP_ADDR_W each: the host and destination IPs.
REQ-010 SHALL have port pkt_in_payload, input, payload_buf_struct: the payload address and length.
REQ-011 SHALL have port pkt_out_val, output, 1 bit: the head entry is valid.
REQ-012 SHALL have port pkt_out_rdy, input, 1 bit: the downstream packet assembler accepts the head.
REQ-013 SHALL have ports pkt_out_hdr, pkt_out_flowid, pkt_out_src_ip, pkt_out_dst_ip and pkt_out_payload, outputs, with widths matching the corresponding inputs: the head entry fields.
REQ-014 SHALL have port queue_count, output, $clog2(DEPTH)+1 bits: the current occupancy.
REQ-015 SHALL have port queue_afull, output, 1 bit: backpressure to the TX scheduler.
REQ-016 SHALL have port stat_clear, input, 1 bit: a synchronous clear of the statistics.
REQ-017 SHALL have ports stat_pkt_cnt and stat_byte_cnt, outputs, 32 bits each: dequeued packets and dequeued payload bytes.

Function
REQ-018 SHALL implement a first-word-fall-through FIFO.
- push = pkt_in_val & pkt_in_rdy.
- pop = pkt_out_val & pkt_out_rdy.
REQ-019 SHALL drive pkt_in_rdy = (queue_count != DEPTH), with no combinational dependence on pkt_out_rdy; when full, a simultaneous pop does not enable a push in the same cycle.
REQ-020 SHALL drive pkt_out_val = (queue_count != 0), with no empty bypass.
- A descriptor pushed in cycle N appears on pkt_out_* in cycle N+1.
REQ-021 SHALL hold the pkt_out_* data stable while pkt_out_val is high and pkt_out_rdy is low.
REQ-022 SHALL advance the write and read pointers modulo DEPTH on push and pop respectively; wrap-around is seamless and order is preserved.
REQ-023 SHALL update queue_count as +1 on push only, -1 on pop only, and unchanged on push and pop together or on neither.
REQ-024 SHALL never overflow or underflow: a push when full and a pop when empty are impossible by the handshake, and no state changes.
REQ-025 SHALL register queue_afull as (next count >= AFULL_THRESH), so it is valid in the same cycle as queue_count.
REQ-026 SHALL update the statistics on each pop.
- stat_pkt_cnt += 1.
- stat_byte_cnt += the zero-extended pkt_out_payload.payload_len.
- Both wrap modulo 2^32.
REQ-027 SHALL give stat_clear priority over a coincident pop, so the counters read 0 in the next cycle.
REQ-028 SHALL accept a descriptor with payload_len = 0 (pure ACK) like any other entry; it adds 0 bytes.

Reset
REQ-029 SHALL, on rst_n low at any time, asynchronously clear the pointers, queue_count, queue_afull, stat_pkt_cnt and stat_byte_cnt to 0.
- As a result, pkt_out_val = 0 and pkt_in_rdy = 1 while in reset.
REQ-030 SHALL discard entries in flight at reset; storage contents are not reset, and pkt_out_* data are don't-care while pkt_out_val = 0.
REQ-031 SHALL leave reset on the first clk edge after rst_n rises; a push is accepted on that edge.

Structure
REQ-032 SHALL define tx_pkt_desc_struct (hdr, flowid, src_ip, dst_ip, payload) in tcp_misc_pkg, with the same struct used for the storage array.
REQ-033 SHALL reuse tcp_pkt_hdr and payload_buf_struct from the existing packages; no new constants are needed beyond the parameters.
REQ-034 SHALL contain one natural sub-module, tcp_tx_pkt_queue_stats (statistics counters with clear), instantiated once.

Verification
REQ-035 SHALL cover single descriptor flow: push flowid=3, payload_len=100 with pkt_out_rdy=1 -> pkt_out_val high next cycle, then pop; count goes 1 then 0; stat_pkt_cnt=1, stat_byte_cnt=100.
REQ-036 SHALL cover fill to full: push 8 descriptors with pkt_out_rdy=0 -> pkt_in_rdy=0 and queue_count=8; queue_afull asserts when count reaches 6; a 9th pushed value is not accepted.
REQ-037 SHALL cover simultaneous push and pop at count=4 for 20 cycles -> count stays 4, the pointers wrap, and output order matches input order (flowid 0..19).
REQ-038 SHALL cover stat wrap and clear: preload stat_byte_cnt to 0xFFFFFFF0 and pop payload_len=0x20 -> stat_byte_cnt=0x10; stat_clear together with a pop -> both counters 0.
REQ-039 SHALL cover reset mid-operation: rst_n low with count=5 -> immediately pkt_out_val=0, queue_count=0, pkt_in_rdy=1; after release, a new push appears first at the output.
REQ-040 SHALL cover random val/rdy for 10k cycles against a scoreboard -> no loss, no duplication, in-order delivery, and byte totals matching.
